// File: rtl/dual_lane_serializer_pkg.sv
// Shared defaults, FSM encoding and frame-length derivation for the dual-lane serializer.
// Optional feature macro: SERIALIZER_PARITY_EN (appends an even-parity bit to every frame).
package dual_lane_serializer_pkg;

    localparam int unsigned DataSizeDef   = 8;
    localparam logic [7:0]  IdleSymDef    = 8'hBC;
    localparam int unsigned SyncFramesDef = 4;

    localparam logic [1:0] StRst   = 2'd0;
    localparam logic [1:0] StTrain = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;

    function automatic int unsigned frame_len(input int unsigned data_size);
`ifdef SERIALIZER_PARITY_EN
        return data_size + 1;
`else
        return data_size;
`endif
    endfunction

endpackage

// File: rtl/serializer_lane.sv
// One serializer lane: training FSM, bit/frame counters, shift register and handshake.
// Optional feature macro: SERIALIZER_PARITY_EN (frame = symbol followed by even parity).
module serializer_lane
    import dual_lane_serializer_pkg::*;
#(
    parameter int unsigned         DataSize   = DataSizeDef,
    parameter logic [DataSize-1:0] IdleSym    = IdleSymDef,
    parameter int unsigned         SyncFrames = SyncFramesDef
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [DataSize-1:0] data_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic                ser_o,
    output logic                sync_o
);

    localparam int unsigned    FrameLen  = frame_len(DataSize);
    localparam int unsigned    CntW      = (FrameLen > 1) ? $clog2(FrameLen) : 1;
    localparam int unsigned    FrmW      = $clog2(SyncFrames + 1);
    localparam logic [CntW-1:0] LastBit   = CntW'(FrameLen - 1);
    localparam logic [FrmW-1:0] LastTrain = FrmW'(SyncFrames - 1);

    logic [1:0]          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [FrmW-1:0]     frm_q, frm_d;
    logic [FrameLen-1:0] shreg_q, shreg_d;
    logic                ready_q, ready_d;
    logic                sync_q, sync_d;

    function automatic logic [FrameLen-1:0] build_frame(input logic [DataSize-1:0] sym);
`ifdef SERIALIZER_PARITY_EN
        return {sym, ^sym};
`else
        return sym;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frm_d   = frm_q;
        shreg_d = shreg_q;
        case (state_q)
            StRst: begin
                state_d = StTrain;
                cnt_d   = '0;
                frm_d   = '0;
                shreg_d = build_frame(IdleSym);
            end
            default: begin
                if (cnt_q == LastBit) begin
                    cnt_d = '0;
                    // ready_q is only ever high when this wrap may take a user byte
                    shreg_d = build_frame((valid_i && ready_q) ? data_i : IdleSym);
                    if (state_q == StTrain) begin
                        if (frm_q == LastTrain) begin
                            state_d = StRun;
                        end else begin
                            frm_d = frm_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    shreg_d = shreg_q << 1;
                end
            end
        endcase

        ready_d = (cnt_d == LastBit) &&
                  ((state_d == StRun) || ((state_d == StTrain) && (frm_d == LastTrain)));
        sync_d  = (state_d == StRun);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StRst;
            cnt_q   <= '0;
            frm_q   <= '0;
            shreg_q <= '0;
            ready_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frm_q   <= frm_d;
            shreg_q <= shreg_d;
            ready_q <= ready_d;
            sync_q  <= sync_d;
        end
    end

    assign ser_o   = shreg_q[FrameLen-1];
    assign ready_o = ready_q;
    assign sync_o  = sync_q;

endmodule

// File: rtl/dual_lane_serializer.sv
// Two independent byte-to-serial lanes sharing one clock, MSB first, idle-symbol fill.
// Optional feature macro: SERIALIZER_PARITY_EN (even-parity bit appended to each frame).
module dual_lane_serializer
    import dual_lane_serializer_pkg::*;
#(
    parameter int unsigned          DATA_SIZE   = DataSizeDef,
    parameter logic [DATA_SIZE-1:0] IDLE_SYM    = IdleSymDef,
    parameter int unsigned          SYNC_FRAMES = SyncFramesDef
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] in0,
    input  logic                 valid0,
    input  logic [DATA_SIZE-1:0] in1,
    input  logic                 valid1,
    output logic                 ready0,
    output logic                 ready1,
    output logic                 out0,
    output logic                 out1,
    output logic                 sync0,
    output logic                 sync1
);

    serializer_lane #(
        .DataSize  (DATA_SIZE),
        .IdleSym   (IDLE_SYM),
        .SyncFrames(SYNC_FRAMES)
    ) u_lane0 (
        .clk_i  (clk),
        .rst_ni (reset),
        .data_i (in0),
        .valid_i(valid0),
        .ready_o(ready0),
        .ser_o  (out0),
        .sync_o (sync0)
    );

    serializer_lane #(
        .DataSize  (DATA_SIZE),
        .IdleSym   (IDLE_SYM),
        .SyncFrames(SYNC_FRAMES)
    ) u_lane1 (
        .clk_i  (clk),
        .rst_ni (reset),
        .data_i (in1),
        .valid_i(valid1),
        .ready_o(ready1),
        .ser_o  (out1),
        .sync_o (sync1)
    );

endmodule

// File: tb/tb_dual_lane_serializer.sv
// Scoreboard bench for dual_lane_serializer: expected serial bits queued per lane,
// a negedge monitor pops and compares them against out0/out1.
module tb_dual_lane_serializer;

    localparam logic [7:0] IDLE = 8'hBC;
    localparam int         S    = 4;
`ifdef SERIALIZER_PARITY_EN
    localparam int L = 9;
`else
    localparam int L = 8;
`endif
    localparam int SL = S * L;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic [7:0] in0    = 8'h00;
    logic [7:0] in1    = 8'h00;
    logic       valid0 = 1'b0;
    logic       valid1 = 1'b0;
    logic       ready0, ready1, out0, out1, sync0, sync1;

    int checks = 0;
    int errors = 0;
    int cyc    = -1;
    bit mon_en = 1'b0;
    bit q0[$];
    bit q1[$];
    bit b0, b1;

    dual_lane_serializer dut (
        .clk   (clk),
        .reset (reset),
        .in0   (in0),
        .valid0(valid0),
        .in1   (in1),
        .valid1(valid1),
        .ready0(ready0),
        .ready1(ready1),
        .out0  (out0),
        .out1  (out1),
        .sync0 (sync0),
        .sync1 (sync1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic push_frame(input int lane, input logic [7:0] sym);
        for (int i = 7; i >= 0; i--) begin
            if (lane == 0) q0.push_back(sym[i]);
            else           q1.push_back(sym[i]);
        end
`ifdef SERIALIZER_PARITY_EN
        if (lane == 0) q0.push_back(^sym);
        else           q1.push_back(^sym);
`endif
    endtask

    task automatic start();
        @(negedge clk);
        #2;
        reset  = 1'b1;
        mon_en = 1'b1;
        cyc    = -1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("rst_out0", out0, 0);
        chk("rst_out1", out1, 0);
        chk("rst_ready0", ready0, 0);
        chk("rst_ready1", ready1, 0);
        chk("rst_sync0", sync0, 0);
        chk("rst_sync1", sync1, 0);
    endtask

    task automatic drained();
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q0.size() > 0) begin
                b0 = q0.pop_front();
                chk("out0_bit", out0, b0);
            end
            if (q1.size() > 0) begin
                b1 = q1.pop_front();
                chk("out1_bit", out1, b1);
            end
        end
    end

    initial begin
        #1;
        do_reset();
        repeat (2) @(negedge clk);

        // Idle training, then A5 on lane 0, then a rejected pulse while ready0 is low
        for (int f = 0; f < S; f++) begin
            push_frame(0, IDLE);
            push_frame(1, IDLE);
        end
        push_frame(0, 8'hA5);
        push_frame(0, IDLE);
        push_frame(0, IDLE);
        for (int f = 0; f < 3; f++) push_frame(1, IDLE);
        in0    = 8'hA5;
        valid0 = 1'b1;
        start();
        run_to(SL - 2);
        chk("ready0_early", ready0, 0);
        chk("sync0_train", sync0, 0);
        run_to(SL - 1);
        chk("ready0_first", ready0, 1);
        chk("ready1_first", ready1, 1);
        chk("sync0_pre", sync0, 0);
        run_to(SL);
        chk("ready0_after", ready0, 0);
        chk("sync0_rise", sync0, 1);
        chk("sync1_rise", sync1, 1);
        valid0 = 1'b0;
        run_to(SL + 3);
        in0    = 8'hFF;
        valid0 = 1'b1;
        run_to(SL + 4);
        chk("ready0_mid", ready0, 0);
        valid0 = 1'b0;
        run_to(SL + L - 1);
        chk("ready0_second", ready0, 1);
        run_to(7 * L - 1);
        drained();

        // Back-to-back bytes on both lanes
        do_reset();
        repeat (2) @(negedge clk);
        for (int f = 0; f < S; f++) begin
            push_frame(0, IDLE);
            push_frame(1, IDLE);
        end
        push_frame(0, 8'h12);
        push_frame(0, 8'h34);
        push_frame(0, IDLE);
        push_frame(1, 8'hA5);
        push_frame(1, 8'h01);
        push_frame(1, IDLE);
        in0    = 8'h12;
        in1    = 8'hA5;
        valid0 = 1'b1;
        valid1 = 1'b1;
        start();
        run_to(SL);
        in0 = 8'h34;
        in1 = 8'h01;
        run_to(SL + L - 2);
        chk("b2b_ready0_low", ready0, 0);
        run_to(SL + L - 1);
        chk("b2b_ready0", ready0, 1);
        chk("b2b_ready1", ready1, 1);
        run_to(SL + L);
        valid0 = 1'b0;
        valid1 = 1'b0;
        run_to(7 * L - 1);
        drained();

        // Reset mid-frame, then a fresh full training before the next accept
        do_reset();
        repeat (2) @(negedge clk);
        for (int f = 0; f < S; f++) begin
            push_frame(0, IDLE);
            push_frame(1, IDLE);
        end
        start();
        run_to(SL + 3);
        chk("mid_sync0", sync0, 1);
        run_to(SL + 4);
        #2;
        do_reset();
        chk("mid_q0_empty", q0.size(), 0);
        repeat (3) @(negedge clk);
        for (int f = 0; f < S; f++) begin
            push_frame(0, IDLE);
            push_frame(1, IDLE);
        end
        push_frame(0, 8'hA5);
        push_frame(1, IDLE);
        in0    = 8'hA5;
        valid0 = 1'b1;
        start();
        run_to(SL - 1);
        chk("retrain_sync0", sync0, 0);
        chk("retrain_ready0", ready0, 1);
        run_to(SL);
        chk("retrain_sync0_rise", sync0, 1);
        valid0 = 1'b0;
        run_to(5 * L - 1);
        drained();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_lane_serializer.md
# dual_lane_serializer

Two-lane byte-to-serial transmit stage that consumes the two 8-bit routed outputs of the switching device (lane 0 and lane 1) and drives one serial bit per lane per clock, MSB first. Each lane sends a fixed idle-symbol training sequence after reset. It then accepts bytes through a valid/ready handshake and inserts the idle symbol whenever no byte is offered. It is the last stage before the physical link.

## Interface
Parameters:
- DATA_SIZE, 8, byte width per lane
- IDLE_SYM, 8'hBC, symbol sent when a lane has no data
- SYNC_FRAMES, 4, idle frames sent after reset before the lane is usable (≥1)

Ports:
- clk  input  1  single system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
- in0  input  DATA_SIZE  lane 0 byte
- valid0  input  1  in0 holds a byte to send
- in1  input  DATA_SIZE  lane 1 byte
- valid1  input  1  in1 holds a byte to send
- ready0  output  1  lane 0 accepts in0 at the next rising edge when valid0=1
- ready1  output  1  lane 1 ready, same rule
- out0  output  1  lane 0 serial bit
- out1  output  1  lane 1 serial bit
- sync0  output  1  lane 0 training complete, carrying user frames
- sync1  output  1  lane 1 sync, same rule

## Operation
- The two lanes are identical and fully independent. The shared clock is their only coupling.
- FRAME_LEN = DATA_SIZE, or DATA_SIZE+1 with parity (see Configuration).
- Per-lane FSM states:
  - RST: held while reset=0.
  - TRAIN: sends SYNC_FRAMES frames of IDLE_SYM.
  - RUN: every frame is either an accepted byte or IDLE_SYM.
- Transitions:
  - RST→TRAIN: first rising edge with reset=1. That edge loads IDLE_SYM.
  - TRAIN→RUN: at the load edge that ends the last training frame.
- Bit counter runs 0..FRAME_LEN-1 and wraps. A new frame is loaded at every wrap edge, with no gaps between frames.
- Load rule at a wrap edge:
  - In RUN, or on the last TRAIN frame: valid=1 loads `in`; valid=0 loads IDLE_SYM.
  - On earlier TRAIN frames: always load IDLE_SYM; `in` is ignored.
- Handshake:
  - `ready` is high only in the cycle before a wrap edge where a load from `in` is allowed.
  - A transfer occurs when valid & ready are both 1 at a rising edge.
  - valid without ready causes no transfer. The producer must hold the byte.
  - No buffering: at most one byte in flight per lane.
- Serial order: bit DATA_SIZE-1 first, then down to bit 0, then the parity bit if enabled.
- Reset asserted mid-frame: the partial frame is discarded and all outputs clear immediately. Training restarts after release.
- Reset values: out0=out1=0, ready0=ready1=0, sync0=sync1=0, FSM=RST, counters=0.

## Timing
- All outputs are registered.
- Let E0 be the first rising edge after reset release; Ek is the k-th edge after it.
- Frame n occupies out during the cycles following edges E(n·FRAME_LEN) through E(n·FRAME_LEN+FRAME_LEN-1).
- ready is high in the cycle following edge E(m·FRAME_LEN-1) for m ≥ SYNC_FRAMES.
  - With defaults, the first ready is the cycle after E31.
  - A byte accepted at E32 shows its MSB after E32 and its LSB after E39.
- sync rises at edge E(SYNC_FRAMES·FRAME_LEN) and stays 1 until reset.
- Latency from accept edge to first serial bit: 0 cycles (the bit is visible after the accept edge).
- Throughput: one byte per FRAME_LEN cycles per lane.

## Configuration
- SERIALIZER_PARITY_EN:
  - Defined: each frame appends one even-parity bit after bit 0, so FRAME_LEN = DATA_SIZE+1. The parity bit is computed over the loaded symbol. Idle frames carry parity too (IDLE_SYM=BC → 1).
  - Undefined: FRAME_LEN = DATA_SIZE and no parity bit is sent.
- Handshake and sync rules are unchanged either way; only the frame length differs.

## Structure
- Shared package holds:
  - DATA_SIZE default
  - IDLE_SYM default
  - SYNC_FRAMES default
  - FSM state encoding (RST, TRAIN, RUN)
  - FRAME_LEN derivation
- Sub-module serializer_lane contains one FSM, bit counter, frame counter, shift register and ready/sync logic.
- dual_lane_serializer instantiates serializer_lane twice and wires the ports through.

## Test plan
- Reset asserted → out0, out1, ready*, sync* all 0. Release with no valid → both lanes emit 10111100 repeated. First ready is after E31; sync rises at E32.
- Lane 0 valid=1, in0=A5 held from reset release → accepted at E32. out0 = 1,0,1,0,0,1,0,1 after E32..E39. out1 stays idle (BC).
- Back-to-back: in0=12 at E32, then 34 at E40 → contiguous bitstream 00010010 00110100 with no idle between. ready is high only after E31 and E39.
- valid0 pulsed high where ready0=0 (after E35) then dropped → no transfer; the lane keeps sending BC.
- reset driven low after E36 mid-frame → outputs clear immediately. After release, a fresh 32-cycle training sequence precedes the next accept.
- SERIALIZER_PARITY_EN defined:
  - Frames are 9 bits; idle frame is BC followed by 1.
  - in1=A5 accepted at E36 → A5 bits then parity 0.
  - in1=01 → parity 1.
